// File: rtl/vx_result_merge_pkg.sv
// Shared types, field positions and width helpers for the result merge block.
package vx_result_merge_pkg;

  localparam int UUID_WIDTH  = 16;
  localparam int LID_WIDTH   = 2;
  localparam int WID_WIDTH   = 2;
  localparam int PC_WIDTH    = 32;
  localparam int RD_WIDTH    = 5;
  localparam int XLEN        = 32;
  localparam int SIMD_WIDTH  = 4;
  localparam int NUM_THREADS = 16;

  localparam int RESULT_EOP_BIT = 0;
  localparam int RESULT_SOP_BIT = 1;
  localparam int RESULT_PID_LSB = 2;

  typedef enum logic {
    MERGE_IDLE,
    MERGE_LOCKED
  } merge_state_e;

  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // uuid, lid, wid, tmask, PC, wb, rd, lane data, pid, sop, eop
  function automatic int result_dataw(input int num_lanes, input int pid_width);
    return UUID_WIDTH + LID_WIDTH + WID_WIDTH + num_lanes + PC_WIDTH + 1 +
           RD_WIDTH + num_lanes * XLEN + pid_width + 2;
  endfunction

endpackage

// File: rtl/vx_result_merge_ebuf.sv
// Two-entry elastic buffer; allows pop-then-push in the same cycle when full.
module vx_result_merge_ebuf #(
  parameter int DATAW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [DATAW-1:0] data_in,
  output logic             ready_in,
  output logic             valid_out,
  output logic [DATAW-1:0] data_out,
  input  logic             ready_out
);

  logic [DATAW-1:0] mem_q [2];
  logic [DATAW-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             push, pop;

  assign ready_in  = (count_q != 2'd2) | ready_out;
  assign valid_out = (count_q != 2'd0);
  assign data_out  = mem_q[rd_ptr_q];
  assign push      = valid_in & ready_in;
  assign pop       = valid_out & ready_out;

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage registers; reset empties the buffer and clears contents
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/vx_result_merge.sv
// Packet-atomic round-robin merge of result streams with per-input framing check.
module vx_result_merge
  import vx_result_merge_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int NUM_LANES  = SIMD_WIDTH,
  parameter int PID_WIDTH  = log2up(NUM_THREADS / NUM_LANES),
  parameter int OUT_BUF    = 1,
  parameter int DATAW      = result_dataw(NUM_LANES, PID_WIDTH),
  parameter int SEL_W      = log2up(NUM_INPUTS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_INPUTS-1:0]       in_valid,
  input  logic [NUM_INPUTS*DATAW-1:0] in_data,
  output logic [NUM_INPUTS-1:0]       in_ready,
  output logic                        out_valid,
  output logic [DATAW-1:0]            out_data,
  output logic [SEL_W-1:0]            out_sel,
  input  logic                        out_ready,
  output logic [NUM_INPUTS-1:0]       err_framing
);

  merge_state_e          state_q, state_d;
  logic [SEL_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0]      lock_idx_q, lock_idx_d;
  logic [PID_WIDTH-1:0]  exp_pid_q [NUM_INPUTS];
  logic [PID_WIDTH-1:0]  exp_pid_d [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] err_q, err_d;

  logic [NUM_INPUTS-1:0] grant;
  logic [SEL_W-1:0]      grant_idx;
  logic                  grant_valid;
  logic                  buf_can_accept;
  logic                  fire;
  logic [DATAW-1:0]      sel_data;
  logic                  sel_sop, sel_eop;
  logic [PID_WIDTH-1:0]  sel_pid;

  // Explicit wrap so non-power-of-2 input counts never land on an unused index
  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] idx);
    if (int'(idx) >= NUM_INPUTS - 1) return '0;
    else return idx + SEL_W'(1);
  endfunction

  // Grant selection: locked input only, else first valid input from rr_ptr
  always_comb begin
    int j;
    j           = 0;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    if (state_q == MERGE_LOCKED) begin
      grant_idx   = lock_idx_q;
      grant_valid = in_valid[lock_idx_q];
    end else begin
      for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
        j = (int'(rr_ptr_q) + k) % NUM_INPUTS;
        if (in_valid[j]) begin
          grant_idx   = SEL_W'(j);
          grant_valid = 1'b1;
        end
      end
    end
    if (grant_valid) grant[grant_idx] = 1'b1;
  end

  assign sel_data = in_data[int'(grant_idx)*DATAW +: DATAW];
  assign sel_sop  = sel_data[RESULT_SOP_BIT];
  assign sel_eop  = sel_data[RESULT_EOP_BIT];
  assign sel_pid  = sel_data[RESULT_PID_LSB +: PID_WIDTH];

  assign in_ready    = reset ? '0 : (grant & {NUM_INPUTS{buf_can_accept}});
  assign fire        = grant_valid & buf_can_accept & ~reset;
  assign err_framing = err_q;

  // Lock FSM, round-robin pointer and framing tracking on each accepted beat
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    exp_pid_d  = exp_pid_q;
    err_d      = err_q;
    if (fire) begin
      if (sel_sop) begin
        if (sel_pid != '0) err_d[grant_idx] = 1'b1;
        if (state_q == MERGE_LOCKED) err_d[grant_idx] = 1'b1;
      end else if (sel_pid != exp_pid_q[grant_idx]) begin
        err_d[grant_idx] = 1'b1;
      end
      exp_pid_d[grant_idx] = sel_eop ? '0 : (sel_pid + PID_WIDTH'(1));
      if (sel_eop) begin
        state_d  = MERGE_IDLE;
        rr_ptr_d = wrap_inc(grant_idx);
      end else if (sel_sop && (state_q == MERGE_IDLE)) begin
        state_d    = MERGE_LOCKED;
        lock_idx_d = grant_idx;
      end
    end
  end

  // Arbiter and checker state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= MERGE_IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
      err_q      <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) exp_pid_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
      err_q      <= err_d;
      exp_pid_q  <= exp_pid_d;
    end
  end

  generate
    if (OUT_BUF != 0) begin : g_buf
      logic                   buf_ready;
      logic [SEL_W+DATAW-1:0] buf_out;

      vx_result_merge_ebuf #(
        .DATAW(SEL_W + DATAW)
      ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (fire),
        .data_in   ({grant_idx, sel_data}),
        .ready_in  (buf_ready),
        .valid_out (out_valid),
        .data_out  (buf_out),
        .ready_out (out_ready)
      );

      assign buf_can_accept = buf_ready;
      assign out_data       = buf_out[DATAW-1:0];
      assign out_sel        = buf_out[SEL_W+DATAW-1 -: SEL_W];
    end else begin : g_comb
      assign buf_can_accept = out_ready;
      assign out_valid      = grant_valid & ~reset;
      assign out_data       = out_valid ? sel_data : '0;
      assign out_sel        = out_valid ? grant_idx : '0;
    end
  endgenerate

endmodule

// File: tb/tb_vx_result_merge.sv
// Directed bench: buffered 4-input merge plus a combinational 3-input merge.
module tb_vx_result_merge;
  import vx_result_merge_pkg::*;

  localparam int DW = result_dataw(4, 2);

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      in_valid;
  logic [4*DW-1:0] in_data;
  logic [3:0]      in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_sel;
  logic            out_ready;
  logic [3:0]      err_framing;

  logic [2:0]      c_in_valid;
  logic [3*DW-1:0] c_in_data;
  logic [2:0]      c_in_ready;
  logic            c_out_valid;
  logic [DW-1:0]   c_out_data;
  logic [1:0]      c_out_sel;
  logic            c_out_ready;
  logic [2:0]      c_err_framing;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  vx_result_merge #(
    .NUM_INPUTS(4), .NUM_LANES(4), .PID_WIDTH(2), .OUT_BUF(1)
  ) dut_buf (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_ready(out_ready), .err_framing(err_framing)
  );

  vx_result_merge #(
    .NUM_INPUTS(3), .NUM_LANES(4), .PID_WIDTH(2), .OUT_BUF(0)
  ) dut_comb (
    .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_data(c_in_data),
    .in_ready(c_in_ready), .out_valid(c_out_valid), .out_data(c_out_data),
    .out_sel(c_out_sel), .out_ready(c_out_ready), .err_framing(c_err_framing)
  );

  function automatic logic [DW-1:0] mk_beat(input logic [7:0] tag, input logic [1:0] pid,
                                            input logic sop, input logic eop);
    logic [DW-1:0] b;
    b            = '0;
    b[DW-1 -: 8] = tag;
    b[40 +: 8]   = tag ^ 8'h5a;
    b[3:2]       = pid;
    b[1]         = sop;
    b[0]         = eop;
    return b;
  endfunction

  task automatic set_in(input int i, input logic [DW-1:0] b);
    in_data[i*DW +: DW] = b;
  endtask

  task automatic set_c_in(input int i, input logic [DW-1:0] b);
    c_in_data[i*DW +: DW] = b;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 4'hF; out_ready = 1'b1; in_data = '0;
    c_in_valid = 3'b111; c_out_ready = 1'b1; c_in_data = '0;
    for (int i = 0; i < 4; i++) set_in(i, mk_beat(8'(16 + i), 2'd0, 1'b1, 1'b1));
    @(negedge clk); #1;
    n_cmp++; if (in_ready !== 4'b0000) begin n_mis++; $display("[TB] FAIL reset_in_ready got=%b exp=0000", in_ready); end
    n_cmp++; if ({out_valid, out_sel} !== 3'b000) begin n_mis++; $display("[TB] FAIL reset_out got valid=%b sel=%0d exp 0/0", out_valid, out_sel); end
    n_cmp++; if (out_data !== '0) begin n_mis++; $display("[TB] FAIL reset_out_data got=%h exp=0", out_data); end
    n_cmp++; if (err_framing !== 4'b0000) begin n_mis++; $display("[TB] FAIL reset_err got=%b exp=0000", err_framing); end
    n_cmp++; if ({c_out_valid, c_in_ready} !== 4'b0000) begin n_mis++; $display("[TB] FAIL reset_comb got valid=%b ready=%b exp 0/000", c_out_valid, c_in_ready); end
    @(negedge clk);
    reset = 1'b0; in_valid = 4'h0; c_in_valid = 3'b000;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_sel;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      in_valid = (c == 8) ? 4'h0 : 4'hF;
      #1;
      if (c < 8) begin
        n_cmp++;
        if (in_ready !== (4'b0001 << (c % 4))) begin
          n_mis++; $display("[TB] FAIL rr_ready c=%0d got=%b exp=%b", c, in_ready, 4'b0001 << (c % 4));
        end
      end
      if (c == 0) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("[TB] FAIL rr_latency got valid=%b exp=0", out_valid); end
      end else begin
        exp_sel = 2'((c - 1) % 4);
        n_cmp++;
        if ({out_valid, out_sel, out_data} !== {1'b1, exp_sel, mk_beat(8'(16 + int'(exp_sel)), 2'd0, 1'b1, 1'b1)}) begin
          n_mis++; $display("[TB] FAIL rr_out c=%0d got valid=%b sel=%0d exp valid=1 sel=%0d", c, out_valid, out_sel, exp_sel);
        end
      end
    end
    @(negedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("[TB] FAIL rr_drain got valid=%b exp=0", out_valid); end
  endtask

  task automatic test_lock();
    logic [DW-1:0] exp_b;
    set_in(2, mk_beat(8'h22, 2'd0, 1'b1, 1'b1));
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k < 4) begin
        in_valid = 4'b0110;
        set_in(1, mk_beat(8'h31, 2'(k), k == 0, k == 3));
      end else if (k == 4) begin
        in_valid = 4'b0100;
      end else begin
        in_valid = 4'b0000;
      end
      #1;
      if (k < 5) begin
        n_cmp++;
        if (in_ready !== ((k < 4) ? 4'b0010 : 4'b0100)) begin
          n_mis++; $display("[TB] FAIL lock_ready k=%0d got=%b exp=%b", k, in_ready, (k < 4) ? 4'b0010 : 4'b0100);
        end
      end
      if (k == 0) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("[TB] FAIL lock_first got valid=%b exp=0", out_valid); end
      end else if (k < 5) begin
        exp_b = mk_beat(8'h31, 2'(k - 1), k == 1, k == 4);
        n_cmp++;
        if ({out_valid, out_sel, out_data} !== {1'b1, 2'd1, exp_b}) begin
          n_mis++; $display("[TB] FAIL lock_beat k=%0d got valid=%b sel=%0d pid=%0d exp valid=1 sel=1 pid=%0d", k, out_valid, out_sel, out_data[3:2], k - 1);
        end
      end else if (k == 5) begin
        n_cmp++;
        if ({out_valid, out_sel, out_data} !== {1'b1, 2'd2, mk_beat(8'h22, 2'd0, 1'b1, 1'b1)}) begin
          n_mis++; $display("[TB] FAIL lock_next got valid=%b sel=%0d exp valid=1 sel=2", out_valid, out_sel);
        end
      end else begin
        n_cmp++;
        if ({out_valid, err_framing} !== 5'b00000) begin
          n_mis++; $display("[TB] FAIL lock_end got valid=%b err=%b exp 0/0000", out_valid, err_framing);
        end
      end
    end
  endtask

  task automatic test_back_pressure();
    logic       rdy_tab [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0] vld_tab [8] = '{4'b0001, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 4'b0000};
    int         pid_tab [8] = '{0, 1, 2, 3, 3, 3, 3, 3};
    logic [3:0] exp_rdy [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
    int         exp_pid [8] = '{-1, 0, 1, 1, 1, 2, 3, -1};
    set_in(2, mk_beat(8'h42, 2'd0, 1'b1, 1'b1));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      out_ready = rdy_tab[k];
      in_valid  = vld_tab[k];
      set_in(0, mk_beat(8'h40, 2'(pid_tab[k]), pid_tab[k] == 0, pid_tab[k] == 3));
      #1;
      if (k < 5) begin
        n_cmp++;
        if (in_ready !== exp_rdy[k]) begin
          n_mis++; $display("[TB] FAIL bp_ready k=%0d got=%b exp=%b", k, in_ready, exp_rdy[k]);
        end
      end
      n_cmp++;
      if (exp_pid[k] < 0) begin
        if (out_valid !== 1'b0) begin n_mis++; $display("[TB] FAIL bp_empty k=%0d got valid=%b exp=0", k, out_valid); end
      end else if ({out_valid, out_sel, out_data} !==
                   {1'b1, 2'd0, mk_beat(8'h40, 2'(exp_pid[k]), exp_pid[k] == 0, exp_pid[k] == 3)}) begin
        n_mis++; $display("[TB] FAIL bp_beat k=%0d got valid=%b sel=%0d pid=%0d exp valid=1 sel=0 pid=%0d", k, out_valid, out_sel, out_data[3:2], exp_pid[k]);
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_framing();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin in_valid = 4'b1000; set_in(3, mk_beat(8'h53, 2'd0, 1'b1, 1'b0)); end
      else if (k == 1) set_in(3, mk_beat(8'h53, 2'd2, 1'b0, 1'b1));
      else in_valid = 4'b0000;
      #1;
      if (k == 0) begin
        n_cmp++; if (in_ready !== 4'b1000) begin n_mis++; $display("[TB] FAIL frm_ready got=%b exp=1000", in_ready); end
      end
      n_cmp++;
      if (err_framing !== ((k < 2) ? 4'b0000 : 4'b1000)) begin
        n_mis++; $display("[TB] FAIL frm_err k=%0d got=%b exp=%b", k, err_framing, (k < 2) ? 4'b0000 : 4'b1000);
      end
      if (k == 2) begin
        n_cmp++;
        if ({out_valid, out_sel, out_data} !== {1'b1, 2'd3, mk_beat(8'h53, 2'd2, 1'b0, 1'b1)}) begin
          n_mis++; $display("[TB] FAIL frm_fwd got valid=%b sel=%0d pid=%0d exp valid=1 sel=3 pid=2", out_valid, out_sel, out_data[3:2]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    set_in(2, mk_beat(8'h62, 2'd0, 1'b1, 1'b1));
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_valid = 4'b0001;
      set_in(0, mk_beat(8'h60, 2'(k), k == 0, 1'b0));
    end
    @(negedge clk);
    in_valid = 4'b0101;
    set_in(0, mk_beat(8'h60, 2'd2, 1'b0, 1'b0));
    reset = 1'b1;
    #1;
    n_cmp++; if ({out_valid, out_data} !== {1'b0, {DW{1'b0}}}) begin n_mis++; $display("[TB] FAIL mid_rst_out got valid=%b exp=0 data=0", out_valid); end
    n_cmp++; if ({in_ready, err_framing} !== 8'h00) begin n_mis++; $display("[TB] FAIL mid_rst_flags got ready=%b err=%b exp 0000/0000", in_ready, err_framing); end
    @(negedge clk);
    reset = 1'b0;
    in_valid = 4'b0100;
    #1;
    n_cmp++; if ({out_valid, in_ready} !== 5'b00100) begin n_mis++; $display("[TB] FAIL mid_release got valid=%b ready=%b exp 0/0100", out_valid, in_ready); end
    @(negedge clk);
    in_valid = 4'b0000;
    #1;
    n_cmp++;
    if ({out_valid, out_sel, out_data} !== {1'b1, 2'd2, mk_beat(8'h62, 2'd0, 1'b1, 1'b1)}) begin
      n_mis++; $display("[TB] FAIL mid_first got valid=%b sel=%0d exp valid=1 sel=2", out_valid, out_sel);
    end
    @(negedge clk); #1;
    n_cmp++; if ({out_valid, err_framing} !== 5'b00000) begin n_mis++; $display("[TB] FAIL mid_end got valid=%b err=%b exp 0/0000", out_valid, err_framing); end
  endtask

  task automatic test_comb_wrap();
    for (int i = 0; i < 3; i++) set_c_in(i, mk_beat(8'(8'h70 + i), 2'd0, 1'b1, 1'b1));
    @(negedge clk);
    c_out_ready = 1'b1; c_in_valid = 3'b100;
    #1;
    n_cmp++;
    if ({c_out_valid, c_out_sel, c_in_ready, c_out_data} !== {1'b1, 2'd2, 3'b100, mk_beat(8'h72, 2'd0, 1'b1, 1'b1)}) begin
      n_mis++; $display("[TB] FAIL comb_same_cycle got valid=%b sel=%0d ready=%b exp valid=1 sel=2 ready=100", c_out_valid, c_out_sel, c_in_ready);
    end
    @(negedge clk);
    c_in_valid = 3'b111;
    #1;
    n_cmp++;
    if ({c_out_valid, c_out_sel, c_in_ready, c_out_data} !== {1'b1, 2'd0, 3'b001, mk_beat(8'h70, 2'd0, 1'b1, 1'b1)}) begin
      n_mis++; $display("[TB] FAIL comb_wrap got valid=%b sel=%0d ready=%b exp valid=1 sel=0 ready=001", c_out_valid, c_out_sel, c_in_ready);
    end
    @(negedge clk);
    c_out_ready = 1'b0;
    #1;
    n_cmp++;
    if ({c_out_valid, c_out_sel, c_in_ready} !== {1'b1, 2'd1, 3'b000}) begin
      n_mis++; $display("[TB] FAIL comb_stall got valid=%b sel=%0d ready=%b exp valid=1 sel=1 ready=000", c_out_valid, c_out_sel, c_in_ready);
    end
    @(negedge clk);
    c_out_ready = 1'b1;
    #1;
    n_cmp++;
    if ({c_out_valid, c_out_sel, c_in_ready} !== {1'b1, 2'd1, 3'b010}) begin
      n_mis++; $display("[TB] FAIL comb_resume got valid=%b sel=%0d ready=%b exp valid=1 sel=1 ready=010", c_out_valid, c_out_sel, c_in_ready);
    end
    @(negedge clk);
    c_in_valid = 3'b000;
    #1;
    n_cmp++;
    if ({c_out_valid, c_err_framing} !== 4'b0000) begin
      n_mis++; $display("[TB] FAIL comb_idle got valid=%b err=%b exp 0/000", c_out_valid, c_err_framing);
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_round_robin();
    test_lock();
    test_back_pressure();
    test_framing();
    test_reset_mid_packet();
    test_comb_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
